// File: rtl/spdif_bmc_decoder.sv
// S/PDIF biphase-mark receiver front end: line sync, interval classing,
// preamble detection and 32-slot subframe decode with lock tracking.
module spdif_bmc_decoder #(
    parameter int UI_CLKS  = 8,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        spdif_i,
    output logic [23:0] sample_o,
    output logic        ch_o,
    output logic        block_start_o,
    output logic [2:0]  vuc_o,
    output logic        parity_err_o,
    output logic        valid_o,
    output logic        lock_o
);
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] T1   = CNT_W'(UI_CLKS / 2);
    localparam logic [CNT_W-1:0] T2   = CNT_W'(3 * UI_CLKS / 2);
    localparam logic [CNT_W-1:0] T3   = CNT_W'(5 * UI_CLKS / 2);
    localparam logic [CNT_W-1:0] T4   = CNT_W'(7 * UI_CLKS / 2);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
    localparam logic [LCW-1:0]   LMAX = LCW'(LOCK_CNT);

    typedef enum logic [1:0] {HUNT, PRE, DATA} state_t;
    typedef enum logic [2:0] {C_NONE, C_GLT, C_S, C_L, C_X, C_TMO} cls_t;

    logic             s1_q, s2_q, s3_q;
    logic             edge_w;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cls_t             cls;

    state_t           state_q, state_d;
    logic [1:0]       pidx_q, pidx_d;
    cls_t             c1_q, c1_d, c2_q, c2_d;
    logic             chn_q, chn_d, blkn_q, blkn_d;
    logic             half_q, half_d;
    logic [4:0]       slot_q, slot_d;
    logic [27:0]      data_q, data_d, nd;
    logic [23:0]      sample_q, sample_d;
    logic             ch_q, ch_d, blk_q, blk_d;
    logic [2:0]       vuc_q, vuc_d;
    logic             perr_q, perr_d;
    logic             valid_q, valid_d;
    logic             lock_q, lock_d;
    logic [LCW-1:0]   lcnt_q, lcnt_d, lnext;
    logic             shift_en, bit_v, err;

    assign edge_w = s2_q ^ s3_q;

    always_comb begin
        cnt_d = cnt_q;
        if (edge_w) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CMAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timeout also fires once, without an edge, as the counter passes T4
    always_comb begin
        cls = C_NONE;
        if (edge_w) begin
            if (cnt_q < T1)      cls = C_GLT;
            else if (cnt_q < T2) cls = C_S;
            else if (cnt_q < T3) cls = C_L;
            else if (cnt_q < T4) cls = C_X;
            else                 cls = C_TMO;
        end else if (cnt_q == T4) begin
            cls = C_TMO;
        end
    end

    assign lnext = (lcnt_q == LMAX) ? lcnt_q : lcnt_q + LCW'(1);

    always_comb begin
        state_d  = state_q;
        pidx_d   = pidx_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        chn_d    = chn_q;
        blkn_d   = blkn_q;
        half_d   = half_q;
        slot_d   = slot_q;
        data_d   = data_q;
        sample_d = sample_q;
        ch_d     = ch_q;
        blk_d    = blk_q;
        vuc_d    = vuc_q;
        perr_d   = perr_q;
        valid_d  = 1'b0;
        lock_d   = lock_q;
        lcnt_d   = lcnt_q;
        shift_en = 1'b0;
        bit_v    = 1'b0;
        err      = 1'b0;
        nd       = {1'b0, data_q[27:1]};

        unique case (state_q)
            HUNT: begin
                if (cls == C_X) begin
                    state_d = PRE;
                    pidx_d  = 2'd1;
                end
            end
            PRE: begin
                if (cls == C_GLT || cls == C_TMO) begin
                    err = 1'b1;
                end else if (cls != C_NONE) begin
                    unique case (pidx_q)
                        2'd0: begin
                            if (cls == C_X) pidx_d = 2'd1;
                            else            err = 1'b1;
                        end
                        2'd1: begin
                            c1_d   = cls;
                            pidx_d = 2'd2;
                        end
                        2'd2: begin
                            c2_d   = cls;
                            pidx_d = 2'd3;
                        end
                        2'd3: begin
                            state_d = DATA;
                            slot_d  = 5'd4;
                            half_d  = 1'b0;
                            if (c1_q == C_S && c2_q == C_S && cls == C_X) begin
                                chn_d  = 1'b0;
                                blkn_d = 1'b1;
                            end else if (c1_q == C_X && c2_q == C_S && cls == C_S) begin
                                chn_d  = 1'b0;
                                blkn_d = 1'b0;
                            end else if (c1_q == C_L && c2_q == C_S && cls == C_L) begin
                                chn_d  = 1'b1;
                                blkn_d = 1'b0;
                            end else begin
                                err = 1'b1;
                            end
                        end
                    endcase
                end
            end
            DATA: begin
                if (cls != C_NONE) begin
                    case (cls)
                        C_S: begin
                            if (!half_q) begin
                                half_d = 1'b1;
                            end else begin
                                shift_en = 1'b1;
                                bit_v    = 1'b1;
                            end
                        end
                        C_L: begin
                            if (!half_q) shift_en = 1'b1;
                            else         err = 1'b1;
                        end
                        default: err = 1'b1;
                    endcase
                end
            end
            default: state_d = HUNT;
        endcase

        nd = {bit_v, data_q[27:1]};
        if (shift_en) begin
            data_d = nd;
            half_d = 1'b0;
            slot_d = slot_q + 5'd1;
            if (slot_q == 5'd31) begin
                state_d  = PRE;
                pidx_d   = 2'd0;
                valid_d  = 1'b1;
                sample_d = nd[23:0];
                vuc_d    = {nd[24], nd[25], nd[26]};
                perr_d   = ^nd;
                ch_d     = chn_q;
                blk_d    = blkn_q;
                lcnt_d   = lnext;
                lock_d   = (lnext == LMAX);
            end
        end

        if (cls == C_TMO) err = 1'b1;
        if (err) begin
            state_d = HUNT;
            valid_d = 1'b0;
            lock_d  = 1'b0;
            lcnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            state_q  <= HUNT;
            pidx_q   <= 2'd0;
            c1_q     <= C_NONE;
            c2_q     <= C_NONE;
            chn_q    <= 1'b0;
            blkn_q   <= 1'b0;
            half_q   <= 1'b0;
            slot_q   <= 5'd0;
            data_q   <= '0;
            sample_q <= '0;
            ch_q     <= 1'b0;
            blk_q    <= 1'b0;
            vuc_q    <= 3'd0;
            perr_q   <= 1'b0;
            valid_q  <= 1'b0;
            lock_q   <= 1'b0;
            lcnt_q   <= '0;
        end else begin
            s1_q     <= spdif_i;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            pidx_q   <= pidx_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            chn_q    <= chn_d;
            blkn_q   <= blkn_d;
            half_q   <= half_d;
            slot_q   <= slot_d;
            data_q   <= data_d;
            sample_q <= sample_d;
            ch_q     <= ch_d;
            blk_q    <= blk_d;
            vuc_q    <= vuc_d;
            perr_q   <= perr_d;
            valid_q  <= valid_d;
            lock_q   <= lock_d;
            lcnt_q   <= lcnt_d;
        end
    end

    assign sample_o      = sample_q;
    assign ch_o          = ch_q;
    assign block_start_o = blk_q;
    assign vuc_o         = vuc_q;
    assign parity_err_o  = perr_q;
    assign valid_o       = valid_q;
    assign lock_o        = lock_q;
endmodule
